// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-triggered, fixed-priority vectored interrupt controller with an enable mask and a non-nesting IDLE/REQ/SERVICE handshake
// Ports:
//   clk             - sole clock, rising edge
//   reset           - asynchronous active-low reset
//   irq_in          - raw source lines; a rising edge raises a request
//   mask_we/mask_wd - enable-mask write strobe and data (bit=1 enables)
//   s_take          - control unit accepts the offered interrupt
//   s_finish_interr - return-from-interrupt executed
//   s_interruption  - interrupt offered to the control unit
//   vector          - ISR address of the offered/in-service source
//   active_id       - index of the offered/in-service source
//   in_service      - an ISR is executing
//   pending         - sticky pending flags
//   mask            - current enable mask
module interrupt_controller #(
  parameter int              NSRC     = 4,
  parameter int              AW       = 10,
  parameter logic [AW-1:0]   VBASE    = 10'h3C0,
  parameter int              VSTRIDE  = 4,
  parameter logic [NSRC-1:0] MASK_RST = {NSRC{1'b1}}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wd,
  input  logic            s_take,
  input  logic            s_finish_interr,
  output logic            s_interruption,
  output logic [AW-1:0]   vector,
  output logic [3:0]      active_id,
  output logic            in_service,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] mask
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t          r_state;
  logic [NSRC-1:0] r_irq_prev;
  logic [NSRC-1:0] r_pending;
  logic [NSRC-1:0] r_mask;
  logic [3:0]      r_active_id;
  logic            r_irq;
  logic            r_insvc;
  logic [NSRC-1:0] w_edge;
  logic [NSRC-1:0] w_req;
  logic [NSRC-1:0] w_clr;
  logic [3:0]      w_sel;
  assign w_edge = irq_in & ~r_irq_prev;
  assign w_req  = r_pending & r_mask;
  // only the committed source is cleared; a coinciding edge re-sets it below
  assign w_clr  = (r_state == REQ && s_take) ? (NSRC'(1) << r_active_id) : '0;
  // lowest set index wins, so scan downward and let the last hit stick
  always_comb begin
    w_sel = '0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (w_req[i]) w_sel = 4'(i);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_irq_prev  <= '0;
      r_pending   <= '0;
      r_mask      <= MASK_RST;
      r_active_id <= '0;
      r_irq       <= 1'b0;
      r_insvc     <= 1'b0;
    end else begin
      r_irq_prev <= irq_in;
      r_pending  <= (r_pending & ~w_clr) | w_edge;
      if (mask_we) r_mask <= mask_wd;
      case (r_state)
        IDLE: if (|w_req) begin
          r_active_id <= w_sel;
          r_state     <= REQ;
          r_irq       <= 1'b1;
        end
        REQ: if (s_take) begin
          r_state <= SERVICE;
          r_irq   <= 1'b0;
          r_insvc <= 1'b1;
        end
        SERVICE: if (s_finish_interr) begin
          r_state <= IDLE;
          r_insvc <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // AW-bit add wraps silently
  assign vector         = VBASE + AW'(int'(r_active_id) * VSTRIDE);
  assign s_interruption = r_irq;
  assign in_service     = r_insvc;
  assign active_id      = r_active_id;
  assign pending        = r_pending;
  assign mask           = r_mask;
endmodule
